// File: rtl/mem_loader.sv
// Byte-stream RAM loader: assembles big-endian 32-bit words from a byte stream,
// writes them to consecutive RAM addresses and holds the CPU in reset until a load finishes.
module mem_loader #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FINISH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              boot_q, boot_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      checksum_q  <= '0;
      boot_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      checksum_q  <= checksum_d;
      boot_q      <= boot_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    checksum_d  = checksum_q;
    boot_d      = boot_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          remain_d   = word_count;
          byte_cnt_d = '0;
          checksum_d = '0;
          state_d    = (word_count == '0) ? FINISH : RECV;
        end
      end
      RECV: begin
        if (in_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {word_q[15:0], in_byte};
          // The write port is loaded here so it holds steady until the next word.
          if (byte_cnt_q == 2'd3) begin
            mem_addr_d  = addr_q;
            mem_wdata_d = {word_q, in_byte};
            state_d     = WRITE;
          end
        end
      end
      WRITE: begin
        checksum_d = checksum_q + mem_wdata_q;
        addr_d     = addr_q + 1'b1;
        remain_d   = remain_q - 1'b1;
        state_d    = (remain_q == 1) ? FINISH : RECV;
      end
      FINISH: begin
        boot_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == RECV);
  assign mem_we    = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign cpu_rst   = boot_q | busy;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader: a per-cycle vector table plus
// hand-written stall/ignored-start and reset-mid-load sequences.
module tb_mem_loader;

   logic       clk;
   logic       rst;
   logic       start;
   logic [6:0] baseAddr;
   logic [7:0] wordCount;
   logic       inValid;
   logic [7:0] inByte;
   logic       inReady;
   logic       memWe;
   logic [6:0] memAddr;
   logic [31:0] memWdata;
   logic       cpuRst;
   logic       busy;
   logic       done;
   logic [31:0] checksum;

   int nVec;
   int nMiss;

   typedef struct {
      logic        rst;
      logic        start;
      logic [6:0]  base;
      logic [7:0]  cnt;
      logic        vld;
      logic [7:0]  byt;
      logic [75:0] exp;
   } vec_t;

   vec_t vecs[$];

   logic [31:0] ram [128];
   logic        ramClear;
   int          writeCount;
   logic [75:0] obs;

   mem_loader #(.ADDR_W(7)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .base_addr(baseAddr),
      .word_count(wordCount),
      .in_valid(inValid),
      .in_byte(inByte),
      .in_ready(inReady),
      .mem_we(memWe),
      .mem_addr(memAddr),
      .mem_wdata(memWdata),
      .cpu_rst(cpuRst),
      .busy(busy),
      .done(done),
      .checksum(checksum)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // All observable outputs packed into one word so a vector is a single comparison.
   assign obs = {inReady, memWe, memAddr, memWdata, busy, done, cpuRst, checksum};

   // Behavioural RAM that records every write strobe from the loader; cleared to a marker first.
   always @(posedge clk) begin
      if (ramClear) begin
         for (int k = 0; k < 128; k++) ram[k] <= 32'hDEADBEEF;
         writeCount <= 0;
      end else if (memWe) begin
         ram[memAddr] <= memWdata;
         writeCount   <= writeCount + 1;
      end
   end

   function automatic vec_t row(input logic r, input logic s, input logic [6:0] b,
                                input logic [7:0] c, input logic v, input logic [7:0] d,
                                input logic eRdy, input logic eWe, input logic [6:0] eAddr,
                                input logic [31:0] eWd, input logic eBusy, input logic eDone,
                                input logic eCpu, input logic [31:0] eCs);
      vec_t t;
      t.rst   = r;
      t.start = s;
      t.base  = b;
      t.cnt   = c;
      t.vld   = v;
      t.byt   = d;
      t.exp   = {eRdy, eWe, eAddr, eWd, eBusy, eDone, eCpu, eCs};
      return t;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst       = v.rst;
      start     = v.start;
      baseAddr  = v.base;
      wordCount = v.cnt;
      inValid   = v.vld;
      inByte    = v.byt;
   endtask

   task automatic checkOutput(input string name, input logic [75:0] got, input logic [75:0] exp);
      nVec++;
      if (got !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [6:0] b, input logic [7:0] c,
                        input logic v, input logic [7:0] d);
      @(negedge clk);
      start     = s;
      baseAddr  = b;
      wordCount = c;
      inValid   = v;
      inByte    = d;
   endtask

   // Builds the vector table, applies it cycle by cycle, then runs the multi-cycle corner cases.
   initial begin
      int wcBefore;
      logic [7:0] bytesA [4];
      nVec = 0;
      nMiss = 0;
      rst = 1'b1;
      ramClear = 1'b1;
      start = 1'b0;
      baseAddr = '0;
      wordCount = '0;
      inValid = 1'b0;
      inByte = '0;

      // Reset state, then cpu_rst must stay high after reset release.
      vecs.push_back(row(1,0,0,0,0,8'h00, 0,0,0,32'h0,0,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,0,8'h00, 0,0,0,32'h0,0,0,1,32'h0));
      // base 0, count 2, bytes 20 19 00 40 00 00 80 20
      vecs.push_back(row(0,1,0,2,0,8'h00, 0,0,0,32'h0,0,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h20, 1,0,0,32'h0,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h19, 1,0,0,32'h0,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h00, 1,0,0,32'h0,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h40, 1,0,0,32'h0,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,0,8'h00, 0,1,0,32'h20190040,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h00, 1,0,0,32'h20190040,1,0,1,32'h20190040));
      vecs.push_back(row(0,0,0,0,1,8'h00, 1,0,0,32'h20190040,1,0,1,32'h20190040));
      vecs.push_back(row(0,0,0,0,1,8'h80, 1,0,0,32'h20190040,1,0,1,32'h20190040));
      vecs.push_back(row(0,0,0,0,1,8'h20, 1,0,0,32'h20190040,1,0,1,32'h20190040));
      vecs.push_back(row(0,0,0,0,0,8'h00, 0,1,1,32'h00008020,1,0,1,32'h20190040));
      vecs.push_back(row(0,0,0,0,0,8'h00, 0,0,1,32'h00008020,1,1,1,32'h20198060));
      // Back in IDLE, cpu_rst released; start base 79, count 1, bytes 00 00 00 05
      vecs.push_back(row(0,1,79,1,0,8'h00, 0,0,1,32'h00008020,0,0,0,32'h20198060));
      vecs.push_back(row(0,0,0,0,1,8'h00, 1,0,1,32'h00008020,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h00, 1,0,1,32'h00008020,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h00, 1,0,1,32'h00008020,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h05, 1,0,1,32'h00008020,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,0,8'h00, 0,1,79,32'h00000005,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,0,8'h00, 0,0,79,32'h00000005,1,1,1,32'h5));
      // IDLE: start with count 0 -> FINISH next cycle, no write
      vecs.push_back(row(0,1,3,0,0,8'h00, 0,0,79,32'h00000005,0,0,0,32'h5));
      vecs.push_back(row(0,0,0,0,0,8'h00, 0,0,79,32'h00000005,1,1,1,32'h0));
      // IDLE: start base 127, count 2 -> writes at 127 then 0
      vecs.push_back(row(0,1,127,2,0,8'h00, 0,0,79,32'h00000005,0,0,0,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h11, 1,0,79,32'h00000005,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h22, 1,0,79,32'h00000005,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h33, 1,0,79,32'h00000005,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h44, 1,0,79,32'h00000005,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,0,8'h00, 0,1,127,32'h11223344,1,0,1,32'h0));
      vecs.push_back(row(0,0,0,0,1,8'h55, 1,0,127,32'h11223344,1,0,1,32'h11223344));
      vecs.push_back(row(0,0,0,0,1,8'h66, 1,0,127,32'h11223344,1,0,1,32'h11223344));
      vecs.push_back(row(0,0,0,0,1,8'h77, 1,0,127,32'h11223344,1,0,1,32'h11223344));
      vecs.push_back(row(0,0,0,0,1,8'h88, 1,0,127,32'h11223344,1,0,1,32'h11223344));
      vecs.push_back(row(0,0,0,0,0,8'h00, 0,1,0,32'h55667788,1,0,1,32'h11223344));
      vecs.push_back(row(0,0,0,0,0,8'h00, 0,0,0,32'h55667788,1,1,1,32'h6688AACC));
      vecs.push_back(row(0,0,0,0,0,8'h00, 0,0,0,32'h55667788,0,0,0,32'h6688AACC));

      @(negedge clk);
      @(negedge clk);
      ramClear = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d", i), obs, vecs[i].exp);
      end

      // Wrapped load landed at 127 then 0; earlier words intact where not overwritten.
      checkOutput("ram127", {44'h0, ram[127]}, {44'h0, 32'h11223344});
      checkOutput("ram0",   {44'h0, ram[0]},   {44'h0, 32'h55667788});
      checkOutput("ram1",   {44'h0, ram[1]},   {44'h0, 32'h00008020});
      checkOutput("ram79",  {44'h0, ram[79]},  {44'h0, 32'h00000005});

      // Stall of 10 cycles after byte 2, with a start pulse in the middle that must be ignored.
      bytesA[0] = 8'hA1;
      bytesA[1] = 8'hB2;
      bytesA[2] = 8'hC3;
      bytesA[3] = 8'hD4;
      drive(1, 10, 1, 0, 8'h00);
      drive(0, 0, 0, 1, bytesA[0]);
      drive(0, 0, 0, 1, bytesA[1]);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) drive(1, 50, 3, 0, 8'hFF);
         else        drive(0, 0, 0, 0, 8'hFF);
      end
      #1;
      checkOutput("stallReady", {75'h0, inReady}, {75'h0, 1'b1});
      drive(0, 0, 0, 1, bytesA[2]);
      drive(0, 0, 0, 1, bytesA[3]);
      drive(0, 0, 0, 0, 8'h00);
      #1;
      checkOutput("stallWrite", {memWe, memAddr, memWdata}, {1'b1, 7'd10, 32'hA1B2C3D4} );
      drive(0, 0, 0, 0, 8'h00);
      #1;
      checkOutput("stallDone", {done, checksum}, {1'b1, 32'hA1B2C3D4});
      drive(0, 0, 0, 1, 8'h00);
      #1;
      checkOutput("stallIdle", {busy, inReady, cpuRst}, {1'b0, 1'b0, 1'b0});
      checkOutput("ignoredStart", {44'h0, ram[50]}, {44'h0, 32'hDEADBEEF});

      // Reset after the 3rd byte of word 2: partial word dropped, word 1 kept.
      drive(1, 20, 2, 0, 8'h00);
      drive(0, 0, 0, 1, 8'h01);
      drive(0, 0, 0, 1, 8'h02);
      drive(0, 0, 0, 1, 8'h03);
      drive(0, 0, 0, 1, 8'h04);
      drive(0, 0, 0, 0, 8'h00);
      drive(0, 0, 0, 1, 8'h05);
      drive(0, 0, 0, 1, 8'h06);
      drive(0, 0, 0, 1, 8'h07);
      @(negedge clk);
      wcBefore = writeCount;
      rst = 1'b1;
      inValid = 1'b0;
      #1;
      checkOutput("midReset", obs, {1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0});
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 8'h08 + 8'(i));
      #1;
      checkOutput("postResetQuiet", {writeCount[31:0], inReady, cpuRst, checksum},
                  {wcBefore[31:0], 1'b0, 1'b1, 32'h0});
      checkOutput("word1Kept",  {44'h0, ram[20]}, {44'h0, 32'h01020304});
      checkOutput("word2Absent", {44'h0, ram[21]}, {44'h0, 32'hDEADBEEF});

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning the word-address width of the target RAM (128 words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, single-cycle request to begin a load.
REQ-005 SHALL have port base_addr, input, ADDR_W, first word address, sampled when start is accepted.
REQ-006 SHALL have port word_count, input, ADDR_W+1, number of words to load, sampled when start is accepted.
REQ-007 SHALL have port in_valid, input, 1, byte-stream valid.
REQ-008 SHALL have port in_byte, input, 8, byte-stream data.
REQ-009 SHALL have port in_ready, output, 1, byte-stream ready; a byte transfers on a cycle where in_valid and in_ready are both 1.
REQ-010 SHALL have port mem_we, output, 1, RAM write strobe.
REQ-011 SHALL have port mem_addr, output, ADDR_W, RAM word address.
REQ-012 SHALL have port mem_wdata, output, 32, RAM write data.
REQ-013 SHALL have port cpu_rst, output, 1, reset to the processor; high holds the CPU in reset.
REQ-014 SHALL have port busy, output, 1, high while a load is in progress.
REQ-015 SHALL have port done, output, 1, single-cycle pulse when a load completes.
REQ-016 SHALL have port checksum, output, 32, modulo-2^32 sum of all words written in the current or last load.

Function
REQ-017 SHALL implement states IDLE, RECV, WRITE, FINISH.
REQ-018 IDLE: start=1 SHALL latch base_addr and word_count, clear checksum and the byte counter, and go to RECV; if word_count=0, SHALL go to FINISH instead.
REQ-019 In any state other than IDLE, start SHALL be ignored.
REQ-020 in_ready SHALL be 1 only in RECV.
REQ-021 Bytes SHALL assemble big-endian: the 1st accepted byte goes to bits 31:24 and the 4th to bits 7:0.
REQ-022 Acceptance of the 4th byte of a word SHALL move the FSM to WRITE.
REQ-023 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr = current address and mem_wdata = assembled word.
REQ-024 The write SHALL occur on the cycle after the 4th byte is accepted.
REQ-025 On leaving WRITE, the FSM SHALL add the word to checksum, increment the address, and decrement the remaining count.
REQ-026 On leaving WRITE, the FSM SHALL go to FINISH if the remaining count reaches 0, else to RECV.
REQ-027 The address SHALL wrap modulo 2^ADDR_W (127+1 -> 0); word_count > 2^ADDR_W SHALL overwrite wrapped locations in order.
REQ-028 FINISH SHALL assert done for one cycle and return to IDLE.
REQ-029 busy SHALL be 1 in RECV, WRITE and FINISH, and 0 in IDLE.
REQ-030 cpu_rst SHALL be 1 from reset until the first FINISH and whenever busy=1.
REQ-031 cpu_rst SHALL fall on the cycle after done.
REQ-032 in_valid=0 mid-word SHALL stall without losing partially assembled bytes; there is no timeout.
REQ-033 mem_we SHALL be 0 in every state except WRITE.
REQ-034 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-035 While rst=1, SHALL force state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, checksum=0 and cpu_rst=1.
REQ-036 Reset mid-load SHALL discard any partial word with no write and leave already-written words untouched.
REQ-037 After rst falls, cpu_rst SHALL remain 1 until a load completes.

Verification
REQ-038 Scenario: start, base=0, count=2, bytes 20 19 00 40 00 00 80 20 -> two writes, mem[0]=32'h20190040 and mem[1]=32'h00008020; checksum=32'h20198060; one done pulse; cpu_rst falls the following cycle.
REQ-039 Scenario: base=79, count=1, bytes 00 00 00 05 -> one write of 32'h00000005 at address 79, issued on the cycle after the 4th byte.
REQ-040 Scenario: base=127, count=2 -> writes at addresses 127 then 0 (wrap).
REQ-041 Scenario: count=0 -> no mem_we, done asserted 1 cycle after start, busy high for that one cycle only.
REQ-042 Scenario: in_valid dropped for 10 cycles after the 2nd byte, plus a start pulse mid-load -> assembled word correct, second start ignored.
REQ-043 Scenario: rst asserted after the 3rd byte of word 2 -> no further writes, cpu_rst=1, checksum=0, word 1 intact in RAM.
